leg_issue_stage: RTL

LEG_ISSUE_STAGE -- requirements
Module: leg_issue_stage

---
 rtl/leg_issue_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/leg_issue_stage.sv
// leg_issue_stage: two-stage issue pipeline in front of an external ALU and register file.
//   D  stage holds one instruction, drives register-file read addresses and resolves operands.
//   WB stage holds the ALU result for one cycle and drives the register-file write port.
// Register 15 is hardwired to zero, so writes to it are suppressed and it never causes a hazard.
// Optional feature: define LEG_ISSUE_FORWARD_EN to forward WDATA into a hazard operand
// (no stall). Without it, a hazard stalls D for one cycle while the write lands.
module leg_issue_stage #(
    parameter int UUID = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [7:0]  R_ADDR1,
    output logic [7:0]  R_ADDR2,
    input  logic [7:0]  READ_1,
    input  logic [7:0]  READ_2,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic [5:0]  alu_op,
    output logic        ex_valid,
    input  logic [7:0]  result,
    output logic        W,
    output logic [7:0]  W_ADDR,
    output logic [7:0]  WDATA
);

    // Instance identifier only; folded into a sink so it counts as used.
    logic unused_uuid;
    assign unused_uuid = ^UUID;

    // Pipeline state
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [7:0]  wb_dest_q, wb_dest_d;
    logic [7:0]  wb_data_q, wb_data_d;

    // Decoded fields of the D-stage instruction
    logic [7:0] d_opcode;
    logic [7:0] d_arg1;
    logic [7:0] d_arg2;
    logic [7:0] d_dest;
    logic       imm_a;
    logic       imm_b;

    // Hazard / handshake
    logic hazard_a;
    logic hazard_b;
    logic hazard;
    logic stall;
    logic advance;
    logic accept;

    assign d_opcode = d_instr_q[7:0];
    assign d_arg1   = d_instr_q[15:8];
    assign d_arg2   = d_instr_q[23:16];
    assign d_dest   = d_instr_q[31:24];
    assign imm_a    = d_opcode[7];
    assign imm_b    = d_opcode[6];

    // Writeback port: the strobe is masked for r15 but address/data still follow WB.
    assign W      = wb_valid_q && (wb_dest_q[3:0] != 4'hF);
    assign W_ADDR = wb_dest_q;
    assign WDATA  = wb_data_q;

    // Read addresses come straight from the held D instruction; since D only reloads on
    // acceptance, they keep their last value while D is empty.
    assign R_ADDR1 = d_arg1;
    assign R_ADDR2 = d_arg2;
    assign alu_op  = d_opcode[5:0];

    // Hazard: a register source matches the register being written this cycle.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        if (d_valid_q && W) begin
            hazard_a = !imm_a && (d_arg1[3:0] == W_ADDR[3:0]);
            hazard_b = !imm_b && (d_arg2[3:0] == W_ADDR[3:0]);
        end
        hazard = hazard_a || hazard_b;
    end

`ifdef LEG_ISSUE_FORWARD_EN
    // Forwarding: the hazard operand takes the value being written, never stall.
    always_comb begin
        stall = 1'b0;
        op_a  = imm_a ? d_arg1 : READ_1;
        op_b  = imm_b ? d_arg2 : READ_2;
        if (hazard_a) begin
            op_a = WDATA;
        end
        if (hazard_b) begin
            op_b = WDATA;
        end
    end
`else
    // No forwarding: hold D one cycle so the write reaches the register file first.
    always_comb begin
        stall = hazard;
        op_a  = imm_a ? d_arg1 : READ_1;
        op_b  = imm_b ? d_arg2 : READ_2;
    end
`endif

    assign advance     = d_valid_q && !stall;
    assign instr_ready = !d_valid_q || advance;
    assign ex_valid    = advance;
    assign accept      = instr_valid && instr_ready;

    // Next-state for D and WB stages
    always_comb begin
        d_valid_d  = d_valid_q;
        d_instr_d  = d_instr_q;
        wb_valid_d = advance;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        if (accept) begin
            d_valid_d = 1'b1;
            d_instr_d = instr;
        end else if (advance) begin
            d_valid_d = 1'b0;
        end
        if (advance) begin
            wb_dest_d = d_dest;
            wb_data_d = result;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid_q  <= 1'b0;
            d_instr_q  <= 32'h0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= 8'h0;
            wb_data_q  <= 8'h0;
        end else begin
            d_valid_q  <= d_valid_d;
            d_instr_q  <= d_instr_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
        end
    end

endmodule
